// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared FSM encoding and address-field width helpers for the
//            direct-mapped, write-through, no-write-allocate data cache.
// Revision : 1.0  initial release
// ============================================================================
package dcache_pkg;

  // Controller states: idle lookup, read fill, write-through to memory
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RFILL = 2'd1,
    WMEM  = 2'd2
  } state_t;

  // Index width for a given number of one-word lines (at least one bit)
  function automatic int idx_width(input int nlines);
    return (nlines > 1) ? $clog2(nlines) : 1;
  endfunction

  // Tag covers everything above the index and the two byte-offset bits
  function automatic int tag_width(input int nlines);
    return 30 - idx_width(nlines);
  endfunction

  // Widths for the default 16-line geometry
  localparam int c_nlines_default = 16;
  localparam int c_idx_w_default  = idx_width(c_nlines_default);
  localparam int c_tag_w_default  = tag_width(c_nlines_default);

endpackage
`default_nettype wire

// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_if
// Purpose  : CPU-side and backing-memory-side signals of the data cache,
//            plus the hit/miss statistics counters.
// Revision : 1.0  initial release
// ============================================================================
interface dcache_if #(
  parameter int CNTW = 16
);
  // CPU side
  logic [31:0]     cpu_addr;
  logic            cpu_rd;
  logic            cpu_wr;
  logic [31:0]     cpu_wdata;
  logic [31:0]     cpu_rdata;
  logic            cpu_stall;
  // Backing memory side
  logic [31:0]     mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic            mem_ack;
  // Statistics
  logic [CNTW-1:0] hit_cnt;
  logic [CNTW-1:0] miss_cnt;

  // The cache controller
  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall, mem_addr, mem_rd, mem_wr, mem_wdata,
           hit_cnt, miss_cnt
  );

  // The environment: CPU pipeline plus backing memory
  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall, mem_addr, mem_rd, mem_wr, mem_wdata,
           hit_cnt, miss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module   : dcache_array
// Purpose  : Valid/tag/data storage for the direct-mapped cache. One
//            combinational read port, one synchronous write port. Only the
//            valid bits are reset; tag and data contents are don't-care
//            until a line is marked valid.
// Revision : 1.0  initial release
// ============================================================================
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NLINES = 16
) (
  input  wire                              clk,
  input  wire                              rst_n,
  input  wire  [idx_width(NLINES)-1:0]     rd_idx,
  output logic                             rd_valid,
  output logic [tag_width(NLINES)-1:0]     rd_tag,
  output logic [31:0]                      rd_data,
  input  wire                              we,
  input  wire  [idx_width(NLINES)-1:0]     wr_idx,
  input  wire  [tag_width(NLINES)-1:0]     wr_tag,
  input  wire  [31:0]                      wr_data
);
  localparam int c_tag_w = tag_width(NLINES);

  logic [NLINES-1:0]  valid_q, valid_d;
  logic [c_tag_w-1:0] tag_mem  [NLINES];
  logic [31:0]        data_mem [NLINES];

  // Any write marks the line valid
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_idx] = 1'b1;
  end

  // Valid bits clear on reset so every line misses afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag/data write; suppressed while reset is asserted so an aborted fill leaves no trace
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, one-word-line data cache controller. Loads hit
//            with zero stall; misses fill from backing memory. Stores are
//            write-through without allocation. Saturating hit/miss counters.
// Revision : 1.0  initial release
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NLINES = 16,
  parameter int CNTW   = 16
) (
  input  wire     clk,
  input  wire     rst_n,
  dcache_if.slave bus
);
  localparam int c_idx_w = idx_width(NLINES);
  localparam int c_tag_w = tag_width(NLINES);

  state_t          state_q, state_d;
  logic [29:0]     addr_q, addr_d;        // latched word address
  logic [31:0]     wdata_q, wdata_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [CNTW-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNTW-1:0] miss_cnt_q, miss_cnt_d;

  logic [c_idx_w-1:0] cpu_idx;
  logic [c_tag_w-1:0] cpu_tag;
  logic               rd_valid;
  logic [c_tag_w-1:0] rd_tag;
  logic [31:0]        rd_data;
  logic               lookup_hit;

  logic               arr_we;
  logic [c_idx_w-1:0] arr_widx;
  logic [c_tag_w-1:0] arr_wtag;
  logic [31:0]        arr_wdata;

  logic               cpu_stall;
  logic [31:0]        cpu_rdata;
  logic               w_unused_byte_offs;

  assign cpu_idx    = bus.cpu_addr[c_idx_w+1:2];
  assign cpu_tag    = bus.cpu_addr[31:c_idx_w+2];
  assign lookup_hit = rd_valid && (rd_tag == cpu_tag);
  // Byte offset is irrelevant for word accesses
  assign w_unused_byte_offs = ^bus.cpu_addr[1:0];

  dcache_array #(
    .NLINES (NLINES)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (cpu_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (arr_we),
    .wr_idx   (arr_widx),
    .wr_tag   (arr_wtag),
    .wr_data  (arr_wdata)
  );

  // Next-state, stall/read-data and array-write decisions
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    cpu_stall  = 1'b0;
    cpu_rdata  = rd_data;
    arr_we     = 1'b0;
    arr_widx   = cpu_idx;
    arr_wtag   = cpu_tag;
    arr_wdata  = bus.cpu_wdata;

    case (state_q)
      IDLE: begin
        if (bus.cpu_wr) begin
          // A store wins over a simultaneous load
          cpu_stall = 1'b1;
          addr_d    = bus.cpu_addr[31:2];
          wdata_d   = bus.cpu_wdata;
          mem_wr_d  = 1'b1;
          state_d   = WMEM;
          arr_we    = lookup_hit;   // update only a resident line
        end else if (bus.cpu_rd) begin
          if (lookup_hit) begin
            hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNTW'(1);
          end else begin
            cpu_stall  = 1'b1;
            addr_d     = bus.cpu_addr[31:2];
            mem_rd_d   = 1'b1;
            miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNTW'(1);
            state_d    = RFILL;
          end
        end
      end
      RFILL: begin
        cpu_stall = !bus.mem_ack;
        cpu_rdata = bus.mem_rdata;
        if (bus.mem_ack) begin
          arr_we    = 1'b1;
          arr_widx  = addr_q[c_idx_w-1:0];
          arr_wtag  = addr_q[29:c_idx_w];
          arr_wdata = bus.mem_rdata;
          mem_rd_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      WMEM: begin
        cpu_stall = !bus.mem_ack;
        if (bus.mem_ack) begin
          mem_wr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // FSM state, memory strobes and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Latched request address and store data (no reset needed)
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.cpu_stall = cpu_stall;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.mem_addr  = {addr_q, 2'b00};
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Scoreboard bench for dcache_ctrl: directed scenarios plus
//            randomized loads/stores against a word-level memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  dcache_if #(.CNTW(16)) bus ();
  dcache_ctrl #(.NLINES(16), .CNTW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Small-counter instance for saturation; memory acks immediately
  dcache_if #(.CNTW(4)) bus2 ();
  dcache_ctrl #(.NLINES(4), .CNTW(4)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));
  assign bus2.mem_ack   = bus2.mem_rd | bus2.mem_wr;
  assign bus2.mem_rdata = 32'hA5A5_0001;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word memory and which word each line holds (-1 = empty)
  logic [31:0] ref_mem [256];
  logic [31:0] bmem    [256];
  int          m_line_word [16];
  int          m_hits, m_miss;
  logic [31:0] exp_q [$];

  // Memory responder state
  int          ack_delay = 1;
  int          wcnt      = 0;
  int          fills     = 0;
  logic [31:0] last_wr_addr = 32'hFFFF_FFFF;
  logic [31:0] last_wr_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_line_word[i] = -1;
    m_hits = 0;
    m_miss = 0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_idle();
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    #1;
    check("idle_stall",  32'(bus.cpu_stall), 32'd0);
    check("idle_mem_rd", 32'(bus.mem_rd),    32'd0);
    check("idle_mem_wr", 32'(bus.mem_wr),    32'd0);
    check("hit_cnt",     32'(bus.hit_cnt),   32'(m_hits));
    check("miss_cnt",    32'(bus.miss_cnt),  32'(m_miss));
  endtask

  // Issue one CPU cycle request and hold it until the stall drops
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int dly);
    int w, idx, stalls, exp_stalls;
    w   = int'(addr[9:2]);
    idx = int'(addr[5:2]);
    ack_delay = dly;
    if (wr) begin
      exp_stalls = dly + 1;
      ref_mem[w] = wd;
    end else if (rd) begin
      if (m_line_word[idx] == w) begin
        exp_stalls = 0;
        if (m_hits < 65535) m_hits++;
      end else begin
        exp_stalls = dly + 1;
        m_line_word[idx] = w;
        if (m_miss < 65535) m_miss++;
      end
      exp_q.push_back(ref_mem[w]);
    end else begin
      exp_stalls = 0;
    end
    @(negedge clk);
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    stalls = 0;
    #1;
    while (bus.cpu_stall && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (wr) begin
      check("wr_addr", last_wr_addr, {addr[31:2], 2'b00});
      check("wr_data", last_wr_data, wd);
    end
  endtask

  // Backing memory: ack after ack_delay full cycles of a strobe
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst_n && (bus.mem_rd || bus.mem_wr)) begin
        wcnt++;
        if (wcnt > ack_delay) begin
          bus.mem_ack = 1'b1;
          wcnt = 0;
          if (bus.mem_wr) begin
            bmem[bus.mem_addr[9:2]] = bus.mem_wdata;
            last_wr_addr = bus.mem_addr;
            last_wr_data = bus.mem_wdata;
          end else begin
            bus.mem_rdata = bmem[bus.mem_addr[9:2]];
            fills++;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pop an expected load value whenever a load completes
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus.mem_rd || bus.mem_wr) begin
          check("strobe_exclusive", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
          check("mem_addr_align",   32'(bus.mem_addr[1:0]),       32'd0);
        end
        if (bus.cpu_rd && !bus.cpu_wr && !bus.cpu_stall) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL load_unexpected: got 0x%08h with no load pending", bus.cpu_rdata);
          end else begin
            exp = exp_q.pop_front();
            check("load_rdata", bus.cpu_rdata, exp);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Saturation scenario on the small instance
  task automatic acc2(input logic [31:0] addr, input int h, input int m);
    int s;
    @(negedge clk);
    bus2.cpu_rd   = 1'b1;
    bus2.cpu_addr = addr;
    s = 0;
    #1;
    while (bus2.cpu_stall && s < 10) begin
      s++;
      @(negedge clk);
      #1;
    end
    check("sat_rdata", bus2.cpu_rdata, 32'hA5A5_0001);
    @(negedge clk);
    bus2.cpu_rd = 1'b0;
    #1;
    check("sat_hit_cnt",  32'(bus2.hit_cnt),  32'((h > 15) ? 15 : h));
    check("sat_miss_cnt", 32'(bus2.miss_cnt), 32'((m > 15) ? 15 : m));
  endtask

  initial begin
    int f0, r, w, h2, m2, cached2;
    logic [31:0] a2;
    bus.cpu_rd = 1'b0;  bus.cpu_wr = 1'b0;
    bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus2.cpu_rd = 1'b0; bus2.cpu_wr = 1'b0;
    bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      bmem[i]    = ref_mem[i];
    end
    ref_mem[16] = 32'h1234_5678;
    bmem[16]    = 32'h1234_5678;

    apply_reset();
    do_idle();                                       // reset state

    do_access(1, 0, 32'h40, 32'h0, 3);               // miss: 4 stalls
    do_idle();
    f0 = fills;
    do_access(1, 0, 32'h40, 32'h0, 3);               // hit: 0 stalls
    do_idle();
    check("hit_no_fill", 32'(fills), 32'(f0));
    do_access(0, 1, 32'h40, 32'hCAFE_F00D, 2);       // store hit
    do_access(1, 0, 32'h40, 32'h0, 2);               // returns new data
    do_access(0, 1, 32'h80, 32'hDEAD_BEEF, 1);       // store miss, same index
    f0 = fills;
    do_access(1, 0, 32'h40, 32'h0, 2);               // old line still hits
    check("store_miss_no_fill", 32'(fills), 32'(f0));
    do_access(1, 0, 32'h80, 32'h0, 1);               // not allocated: miss
    do_idle();

    // Reset in the middle of a fill
    apply_reset();
    ack_delay = 6;
    @(negedge clk);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 32'h44;
    @(negedge clk);
    #1;
    check("rfill_mem_rd", 32'(bus.mem_rd), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.cpu_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
    do_access(1, 0, 32'h44, 32'h0, 2);               // must miss again
    do_idle();

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 47);
      a2 = 32'(w * 4 + $urandom_range(0, 3));
      case (r)
        0, 1, 2, 3, 4: do_access(1, 0, a2, 32'h0, $urandom_range(0, 4));
        5, 6, 7:       do_access(0, 1, a2, $urandom, $urandom_range(0, 4));
        8:             do_access(1, 1, a2, $urandom, $urandom_range(0, 4));
        default:       do_idle();
      endcase
      if ((t % 16) == 15) do_idle();
    end
    do_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Counter saturation with a 4-bit counter instance
    @(negedge clk);
    rst2_n = 1'b1;
    h2 = 0;
    m2 = 0;
    cached2 = -1;
    for (int i = 0; i < 40; i++) begin
      a2 = (i < 20) ? 32'h0 : ((i % 2 == 0) ? 32'h10 : 32'h0);
      if (cached2 == int'(a2)) h2++;
      else begin
        m2++;
        cached2 = int'(a2);
      end
      acc2(a2, h2, m2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
